// File: rtl/opl3_op_slot_sequencer.sv
// OPL3 operator slot sequencer: divides clk down to the sample tick and, on each
// tick, sweeps bank 0 ops 0..NUM_OPS-1 then bank 1 ops 0..NUM_OPS-1, giving each
// operator slot SLOT_CYCLES clocks of the shared operator datapath.
module opl3_op_slot_sequencer #(
  parameter int CLK_DIV_COUNT = 256,
  parameter int NUM_BANKS     = 2,
  parameter int NUM_OPS       = 18,
  parameter int SLOT_CYCLES   = 4,
  localparam int DIV_W  = ($clog2(CLK_DIV_COUNT) > 0) ? $clog2(CLK_DIV_COUNT) : 1,
  localparam int BANK_W = ($clog2(NUM_BANKS)     > 0) ? $clog2(NUM_BANKS)     : 1,
  localparam int OP_W   = ($clog2(NUM_OPS)       > 0) ? $clog2(NUM_OPS)       : 1,
  localparam int SLOT_W = ($clog2(SLOT_CYCLES)   > 0) ? $clog2(SLOT_CYCLES)   : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              sample_clk_en,
  output logic              busy,
  output logic              op_start,
  output logic              op_last_cycle,
  output logic [BANK_W-1:0] bank_num,
  output logic [OP_W-1:0]   op_num,
  output logic [SLOT_W-1:0] slot_cycle,
  output logic              sample_done
);

  // A full sweep must fit inside one sample period, so a tick can never land in RUN.
  if (NUM_BANKS * NUM_OPS * SLOT_CYCLES >= CLK_DIV_COUNT) begin : g_overlap_check
    $error("opl3_op_slot_sequencer: sweep of %0d cycles does not fit in %0d-cycle sample period",
           NUM_BANKS * NUM_OPS * SLOT_CYCLES, CLK_DIV_COUNT);
  end

  // Slot phases need distinct first and last cycles.
  if (SLOT_CYCLES < 2) begin : g_slot_check
    $error("opl3_op_slot_sequencer: SLOT_CYCLES must be at least 2");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [BANK_W-1:0] r_bank;
  logic [BANK_W-1:0] w_bank_nxt;
  logic [OP_W-1:0]   r_op;
  logic [OP_W-1:0]   w_op_nxt;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_nxt;

  logic w_div_wrap;
  logic w_tick;
  logic w_run;
  logic w_slot_last;
  logic w_op_last;
  logic w_bank_last;

  // Full-width terminal-count compares so non-power-of-2 sizes wrap at N-1.
  assign w_div_wrap  = (r_div_cnt == DIV_W'(CLK_DIV_COUNT - 1));
  assign w_tick      = w_div_wrap & enable;
  assign w_run       = (r_state == ST_RUN);
  assign w_slot_last = (r_slot == SLOT_W'(SLOT_CYCLES - 1));
  assign w_op_last   = (r_op   == OP_W'(NUM_OPS - 1));
  assign w_bank_last = (r_bank == BANK_W'(NUM_BANKS - 1));

  // Free-running sample-period divider; enable only gates the tick, not the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_div_wrap) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Sweep state and slot/op/bank indices.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_bank  <= '0;
      r_op    <= '0;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bank  <= w_bank_nxt;
      r_op    <= w_op_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  // Next-state: a tick in IDLE starts a sweep; a tick seen in RUN is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_bank_nxt  = r_bank;
    w_op_nxt    = r_op;
    w_slot_nxt  = r_slot;
    case (r_state)
      ST_IDLE: begin
        w_bank_nxt = '0;
        w_op_nxt   = '0;
        w_slot_nxt = '0;
        if (w_tick) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_slot_last) begin
          w_slot_nxt = '0;
          if (w_op_last) begin
            w_op_nxt = '0;
            if (w_bank_last) begin
              w_bank_nxt  = '0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_bank_nxt = r_bank + 1'b1;
            end
          end else begin
            w_op_nxt = r_op + 1'b1;
          end
        end else begin
          w_slot_nxt = r_slot + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_bank_nxt  = '0;
        w_op_nxt    = '0;
        w_slot_nxt  = '0;
      end
    endcase
  end

  // Every strobe is decoded from the same registered state, keeping them coherent.
  assign sample_clk_en = w_tick;
  assign busy          = w_run;
  assign op_start      = w_run & (r_slot == '0);
  assign op_last_cycle = w_run & w_slot_last;
  assign sample_done   = w_run & w_slot_last & w_op_last & w_bank_last;
  assign bank_num      = r_bank;
  assign op_num        = r_op;
  assign slot_cycle    = r_slot;

endmodule

// File: tb/tb_opl3_op_slot_sequencer.sv
// Scoreboard bench for opl3_op_slot_sequencer: default-size DUT plus a
// SLOT_CYCLES=3 / CLK_DIV_COUNT=200 instance for the non-power-of-2 wrap.
module tb_opl3_op_slot_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;

  logic       sample_clk_en, busy, op_start, op_last_cycle, sample_done;
  logic [0:0] bank_num;
  logic [4:0] op_num;
  logic [1:0] slot_cycle;

  logic       tick_b, busy_b, start_b, last_b, done_b;
  logic [0:0] bank_b;
  logic [4:0] op_b;
  logic [1:0] slot_b;

  always #5 clk = ~clk;

  opl3_op_slot_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_clk_en(sample_clk_en),
    .busy         (busy),
    .op_start     (op_start),
    .op_last_cycle(op_last_cycle),
    .bank_num     (bank_num),
    .op_num       (op_num),
    .slot_cycle   (slot_cycle),
    .sample_done  (sample_done)
  );

  opl3_op_slot_sequencer #(.CLK_DIV_COUNT(200), .SLOT_CYCLES(3)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .enable       (1'b1),
    .sample_clk_en(tick_b),
    .busy         (busy_b),
    .op_start     (start_b),
    .op_last_cycle(last_b),
    .bank_num     (bank_b),
    .op_num       (op_b),
    .slot_cycle   (slot_b),
    .sample_done  (done_b)
  );

  typedef struct {
    int cyc;
    int bank;
    int op;
  } op_exp_t;

  op_exp_t op_q[$];
  int      tick_q[$];
  int      done_q[$];
  int      done_b_q[$];
  int      win_lo[$];
  int      win_hi[$];

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;
  int t = 0;
  int sc = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, t);
    end
  endtask

  // Expected op_start events for a sweep starting at cycle s, cut off after cycle upto.
  task automatic push_sweep(input int s, input int upto);
    op_exp_t e;
    for (int k = 0; k < 36; k++) begin
      if (s + 4 * k <= upto) begin
        e.cyc  = s + 4 * k;
        e.bank = k / 18;
        e.op   = k % 18;
        op_q.push_back(e);
      end
    end
    win_lo.push_back(s);
    win_hi.push_back((s + 143 < upto) ? s + 143 : upto);
  endtask

  task automatic step_to(input int n);
    while (sc < n) begin
      @(posedge clk);
      #1;
      sc++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sample_clk_en"}, sample_clk_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_op_start"}, op_start, 0);
    chk({tag, "_op_last_cycle"}, op_last_cycle, 0);
    chk({tag, "_bank_num"}, bank_num, 0);
    chk({tag, "_op_num"}, op_num, 0);
    chk({tag, "_slot_cycle"}, slot_cycle, 0);
    chk({tag, "_sample_done"}, sample_done, 0);
  endtask

  // Stimulus: reset release at cycle 0, enable gap 300..511, 1-cycle reset at 1100.
  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    started = 1'b1;
    sc      = 0;
    chk_all_zero("reset");

    tick_q.push_back(255);
    tick_q.push_back(767);
    tick_q.push_back(1023);
    tick_q.push_back(1356);
    done_q.push_back(399);
    done_q.push_back(911);
    done_q.push_back(1500);
    push_sweep(256, 100000);
    push_sweep(768, 100000);
    push_sweep(1024, 1100);
    push_sweep(1357, 100000);
    done_b_q.push_back(307);
    done_b_q.push_back(507);
    done_b_q.push_back(707);
    done_b_q.push_back(907);
    done_b_q.push_back(1408);

    step_to(300);
    enable = 1'b0;
    step_to(512);
    enable = 1'b1;
    step_to(1100);
    reset = 1'b1;
    step_to(1101);
    reset = 1'b0;
    chk_all_zero("post_reset");
    step_to(1520);

    chk("tick_q_left", tick_q.size(), 0);
    chk("op_q_left", op_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    chk("done_b_q_left", done_b_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  int  exp_slot = 0;
  bit  prev_busy = 1'b0;
  int  n_start = 0;
  int  n_last = 0;
  bit  prev_busy_b = 1'b0;
  int  len_b = 0;

  // Monitor: sample mid-cycle, pop expected events as the DUTs present them.
  always @(negedge clk) begin
    if (started) begin
      int exp_busy;
      int v;
      op_exp_t e;

      if (sample_clk_en) begin
        if (tick_q.size() == 0) chk("tick_unexpected", t, -1);
        else begin
          v = tick_q.pop_front();
          chk("tick_cycle", t, v);
        end
      end

      exp_busy = 0;
      for (int i = 0; i < win_lo.size(); i++)
        if (t >= win_lo[i] && t <= win_hi[i]) exp_busy = 1;
      chk("busy", busy, exp_busy);

      if (busy && !prev_busy) begin
        n_start = 0;
        n_last  = 0;
      end
      if (busy) begin
        exp_slot = prev_busy ? (exp_slot + 1) % 4 : 0;
        chk("slot_cycle", slot_cycle, exp_slot);
        chk("op_start_decode", op_start, (exp_slot == 0) ? 1 : 0);
        chk("op_last_decode", op_last_cycle, (exp_slot == 3) ? 1 : 0);
        chk("op_num_range", (op_num <= 17) ? 1 : 0, 1);
      end else begin
        chk("idle_zero", {sample_done, op_start, op_last_cycle, bank_num, op_num, slot_cycle}, 0);
      end

      if (op_start) begin
        n_start++;
        if (op_q.size() == 0) chk("op_start_unexpected", t, -1);
        else begin
          e = op_q.pop_front();
          chk("op_start_cycle", t, e.cyc);
          chk("op_start_bank", bank_num, e.bank);
          chk("op_start_op", op_num, e.op);
        end
      end
      if (op_last_cycle) n_last++;

      if (sample_done) begin
        if (done_q.size() == 0) chk("done_unexpected", t, -1);
        else begin
          v = done_q.pop_front();
          chk("done_cycle", t, v);
        end
        chk("sweep_op_starts", n_start, 36);
        chk("sweep_op_lasts", n_last, 36);
      end
      prev_busy = busy;

      if (busy_b && !prev_busy_b) len_b = 0;
      if (busy_b) begin
        len_b++;
        chk("b_slot_range", (slot_b <= 2) ? 1 : 0, 1);
        chk("b_last_decode", last_b, (slot_b == 2) ? 1 : 0);
      end
      if (done_b) begin
        if (done_b_q.size() == 0) chk("b_done_unexpected", t, -1);
        else begin
          v = done_b_q.pop_front();
          chk("b_done_cycle", t, v);
        end
        chk("b_sweep_len", len_b, 108);
      end
      prev_busy_b = busy_b;

      t++;
    end
  end

endmodule
